// File: rtl/mult_pkg.sv
// Shared types and constants for the HI/LO multiply unit.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;
    // One shift-add iteration per multiplier bit.
    localparam int ITER_COUNT    = DEFAULT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/hilo_mult_unit.sv
// Iterative radix-2 shift-add multiplier owning the architectural HI/LO pair.
// Optional signed support (mult) is enabled by defining HILO_MULT_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// RUN   | one shift-add iteration per cycle, down-counter to terminal count 1
// DONE  | HI/LO hold the new product, done pulses, busy still high
import mult_pkg::*;

module hilo_mult_unit #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    mult_state_t state, state_nx;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_d;
    logic               neg_q;

`ifdef HILO_MULT_SIGNED_EN
    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
        neg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    // Unsigned-only build: is_signed is accepted but never changes the result.
    always_comb begin
        a_mag = a;
        b_mag = b;
        neg_d = is_signed & 1'b0;
    end
`endif

    always_comb begin
        acc_nx   = acc + (mplier[0] ? mcand : '0);
        prod_fin = neg_q ? -acc_nx : acc_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // HI/LO are written on the final iteration edge so they are visible in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        neg_q  <= neg_d;
                        cnt    <= CNT_LOAD;
                    end
                end
                ST_RUN: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        {hi, lo} <= prod_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign rd_data = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit: directed vectors, monitor pops on done.
module tb_hilo_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         hilo_sel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] rd_data, hi, lo;
    logic         busy, done;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    logic [2*W-1:0] exp_q[$];

    hilo_mult_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .hilo_sel(hilo_sel), .rd_data(rd_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected product.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hilo_product", {hi, lo}, e);
                    chk("rd_data_at_done", {32'd0, rd_data}, {32'd0, (hilo_sel ? e[63:32] : e[31:0])});
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                         input logic [63:0] e, input bit push);
        a = ta; b = tb_; is_signed = ts; start = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = tb_ ^ 32'h5A5A_A5A5; is_signed = ~ts;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) break;
            if (cyc >= 200) begin
                chk("done_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, busy_cnt, done_cyc, ds;
        logic [63:0] exp_signed;

        #2;
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_rd_data", {32'd0, rd_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap();

        // Unsigned max operands, latency check
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        #2 chk("busy_after_start", {63'd0, busy}, 64'd1);
        wait_done(cyc);
        chk("latency_unsigned", 64'(cyc), 64'(W + 1));
        @(negedge clk);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
        gap();

`ifdef HILO_MULT_SIGNED_EN
        exp_signed = 64'hFFFF_FFFF_FFFF_FFF1;
`else
        exp_signed = 64'h0000_0004_FFFF_FFF1;
`endif
        issue(32'hFFFF_FFFD, 32'd5, 1'b1, exp_signed, 1'b1);
        wait_done(cyc);
        chk("latency_signed", 64'(cyc), 64'(W + 1));
        gap();

        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
        wait_done(cyc);
        gap();

        // Busy rejection: second start while running is ignored
        ds = done_seen;
        busy_cnt = 0;
        done_cyc = 0;
        issue(32'd2, 32'd3, 1'b0, 64'd6, 1'b1);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done && done_cyc == 0) done_cyc = c;
            if (c == 4) begin a = 32'd7; b = 32'd3; start = 1'b1; end
            if (c == 5) start = 1'b0;
        end
        #1;
        chk("reject_busy_cycles", 64'(busy_cnt), 64'(W + 1));
        chk("reject_done_cycle", 64'(done_cyc), 64'(W + 1));
        chk("reject_single_done", 64'(done_seen - ds), 64'd1);
        gap();

        // Reset mid-operation
        issue(32'h22, 32'h8000_0001, 1'b0, 64'h0000_0011_0000_0022, 1'b1);
        wait_done(cyc);
        gap();
        issue(32'd5, 32'd5, 1'b0, 64'd25, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        ds = done_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(done_seen - ds), 64'd0);
        chk("abort_idle", {63'd0, busy}, 64'd0);
        gap();
        issue(32'd3, 32'd4, 1'b0, 64'd12, 1'b1);
        wait_done(cyc);
        chk("latency_after_abort", 64'(cyc), 64'(W + 1));
        gap();

        // Read mux, including during a following RUN
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        wait_done(cyc);
        gap();
        hilo_sel = 1'b1; #1;
        chk("rd_hi_idle", {32'd0, rd_data}, 64'd1);
        hilo_sel = 1'b0; #1;
        chk("rd_lo_idle", {32'd0, rd_data}, 64'd0);
        issue(32'd9, 32'd9, 1'b0, 64'd81, 1'b1);
        repeat (5) @(negedge clk);
        chk("busy_in_run", {63'd0, busy}, 64'd1);
        hilo_sel = 1'b1; #1;
        chk("rd_hi_run", {32'd0, rd_data}, 64'd1);
        hilo_sel = 1'b0; #1;
        chk("rd_lo_run", {32'd0, rd_data}, 64'd0);
        wait_done(cyc);
        repeat (2) @(negedge clk);
        #1;

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
